retro_catc: RTL
===============

// Module: retro_catc
// PURPOSE
//  Clock-Adjusted Timing Controller: derives a core ClkEn at TargetClock from the CLK/CoreClock fabric clock.
//  Uses a phase accumulator and supports 2^n speed modes (GB2x and beyond).
//  Ticks that fall while the core is stalled are buffered and replayed on release, so emulated time is preserved.
//  Sits in the core shim between SysCon and every ClkEn consumer (video, I/O, CPU, mapper).
// PARAMETERS
//  CoreClock     200000000  fabric clock frequency, Hz
//  TargetClock   8388608    base (1x) tick rate, Hz (2^23 = GB)
//  AccWidth      32         phase accumulator width, bits
//  MaxSpeedShift 1          largest SpeedShift accepted (1 => 1x/2x)
//  BacklogWidth  4          backlog counter width; max buffered ticks = 2^BacklogWidth-1
//  CatchUpGap    1          min CLK cycles between replayed ticks (1 = back-to-back)
// PORTS
//  CLK        in   1                    fabric clock (SysCon.CLK)
//  RST        in   1                    reset, asynchronous, active-low
//  Stall      in   1                    core cannot accept a tick this cycle (~(Ready & DataReady))
//  Pause      in   1                    freeze emulated time: accumulator holds, no new ticks
//  SpeedShift in   $clog2(MaxSpeedShift+1)  rate = TargetClock << SpeedShift
//  ClearOvf   in   1                    clears Overflow and DropCount
//  ClkEn      out  1                    one-cycle core clock enable
//  Backlog    out  BacklogWidth         buffered tick count
//  Overflow   out  1                    sticky: a tick was dropped at full backlog
//  DropCount  out  8                    dropped ticks, saturating at 255
// BEHAVIOUR
//  Reset (RST=0, async): Acc=0, Backlog=0, Overflow=0, DropCount=0, ClkEn=0, GapCnt=0, state=RUN.
//  Inc = floor(TargetClock*2^AccWidth/CoreClock), elaboration-time, 64-bit math.
//   Elaboration assertion: (TargetClock<<MaxSpeedShift)*2 <= CoreClock, so at most one tick per CLK.
//  Accumulator: if !Pause, {Carry,Acc} <= Acc + (Inc<<SpeedShift), modulo 2^AccWidth.
//   Tick = Carry, registered; ClkEn is produced the cycle after the wrap (1-cycle latency).
//   SpeedShift is sampled every cycle; a change takes effect next cycle. Acc is never reset by a change.
//   SpeedShift > MaxSpeedShift is clamped to MaxSpeedShift.
//  FSM RUN/STALL/CATCHUP:
//   RUN: Tick & !Stall -> ClkEn=1. Tick & Stall -> Backlog+1, go STALL. !Tick & Stall -> STALL.
//   STALL: ClkEn=0. Each Tick -> Backlog+1. !Stall -> CATCHUP if Backlog>0 (count incl. same-cycle Tick), else RUN.
//   CATCHUP: when GapCnt==0 and !Stall -> ClkEn=1, Backlog-1, GapCnt=CatchUpGap-1.
//    Same-cycle Tick -> Backlog+1, so net change is 0 on a replay cycle.
//    Backlog reaches 0 with no pending Tick -> RUN. Stall -> STALL, holding Backlog and GapCnt.
//  ClkEn: never asserted while Stall=1; at most one pulse per CLK.
//  Full backlog: Tick with Backlog=max -> tick dropped, Overflow=1, DropCount+1 (saturates at 255).
//  ClearOvf: clears Overflow and DropCount. A same-cycle drop wins: Overflow=1, DropCount=1.
//  Pause: blocks new ticks only. Stall handling and replay of the existing Backlog still proceed.
//  Deassertion of RST is synchronised to CLK by the shim; this block assumes a clean release.
// STRUCTURE
//  retro_catc_pkg:
//   - catc_state_t enum {RUN, STALL, CATCHUP}
//   - function catc_increment(CoreClock, TargetClock, AccWidth)
//  Sub-module retro_phase_accum holds Acc, Inc<<SpeedShift, Pause and the registered Tick.
//  retro_catc owns the FSM, backlog, gap counter and drop counters.
// TESTING (bench params CoreClock=16, TargetClock=4, AccWidth=8 -> Inc=64)
//  1. Free run, SpeedShift=0, Stall=0: ClkEn exactly every 4th CLK; first ClkEn 4 CLKs after reset release.
//  2. SpeedShift 0->1 mid-run: period drops to 2 CLK from the next wrap; no missed or double pulse;
//     1000-cycle total = 250*1x portion + 500*2x portion, within 1.
//  3. Stall held 12 CLK at 1x: ClkEn=0 throughout, Backlog=3.
//     On release: 3 back-to-back ClkEn, plus a regular tick landing in the window.
//     Backlog returns to 0; state RUN.
//  4. BacklogWidth=2, Stall 40 CLK: Backlog saturates at 3, Overflow=1, DropCount=7.
//     ClearOvf pulse -> Overflow=0, DropCount=0.
//  5. CatchUpGap=3, Backlog=2, Stall released: replayed ClkEn spaced 3 CLK apart.
//     Stall re-asserted between replays holds Backlog.
//  6. RST asserted mid-CATCHUP (Backlog=2): all outputs 0 immediately (async). After release, behaves as test 1.

Source files
------------

// File: rtl/retro_catc_pkg.sv
// retro_catc_pkg
//   Shared types and elaboration helpers for the clock-adjusted timing
//   controller (retro_catc) and its phase accumulator.
//   - catc_state_t     : controller states RUN / STALL / CATCHUP
//   - catc_increment   : phase increment for a target tick rate
//   - catc_shift_width : width of the speed-shift select
package retro_catc_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        STALL   = 2'd1,
        CATCHUP = 2'd2
    } catc_state_t;

    localparam int DropCountWidth = 8;

    // Computes floor(target * 2^acc_width / core) in 64-bit arithmetic.
    // For the GB defaults this is roughly 0.042 * 2^32, so the shifted
    // numerator stays well inside 64 bits.
    function automatic longint unsigned catc_increment(
        input longint unsigned core_clock,
        input longint unsigned target_clock,
        input int unsigned     acc_width
    );
        return (target_clock << acc_width) / core_clock;
    endfunction

    // A speed-shift select of width zero would be illegal, so a
    // single-speed build still gets one (always clamped) bit.
    function automatic int catc_shift_width(input int max_speed_shift);
        return (max_speed_shift > 0) ? $clog2(max_speed_shift + 1) : 1;
    endfunction

endpackage

// File: rtl/retro_catc_if.sv
// retro_catc_if
//   Control/status bundle between the core shim (master) and the timing
//   controller (slave).
//   master drives : stall, pause, speed_shift, clear_ovf
//   slave drives  : clk_en, backlog, overflow, drop_count
interface retro_catc_if #(
    parameter int MaxSpeedShift = 1,
    parameter int BacklogWidth  = 4
) ();

    localparam int ShiftWidth = retro_catc_pkg::catc_shift_width(MaxSpeedShift);

    logic                    stall;
    logic                    pause;
    logic [ShiftWidth-1:0]   speed_shift;
    logic                    clear_ovf;
    logic                    clk_en;
    logic [BacklogWidth-1:0] backlog;
    logic                    overflow;
    logic [7:0]              drop_count;

    modport master (
        output stall, pause, speed_shift, clear_ovf,
        input  clk_en, backlog, overflow, drop_count
    );

    modport slave (
        input  stall, pause, speed_shift, clear_ovf,
        output clk_en, backlog, overflow, drop_count
    );

endinterface

// File: rtl/retro_phase_accum.sv
// retro_phase_accum
//   Phase accumulator producing the raw emulated-time tick.
//   Ports:
//     clk, rst_n  : fabric clock, asynchronous active-low reset
//     pause       : hold the accumulator, emit no ticks
//     speed_shift : rate = base << speed_shift (clamped to MaxSpeedShift)
//     tick        : registered carry-out of the accumulator, one cycle wide
module retro_phase_accum
    import retro_catc_pkg::*;
#(
    parameter int              AccWidth      = 32,
    parameter int              MaxSpeedShift = 1,
    parameter longint unsigned Inc           = 1,
    localparam int             ShiftWidth    = catc_shift_width(MaxSpeedShift)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pause,
    input  logic [ShiftWidth-1:0] speed_shift,
    output logic                  tick
);

    localparam logic [AccWidth-1:0] IncW = AccWidth'(Inc);

    logic [AccWidth-1:0] acc;
    logic [AccWidth-1:0] step;
    logic [AccWidth:0]   sum;
    logic [31:0]         shift_req;
    logic [31:0]         shift_amt;

    // The shift is compared at 32 bits so the clamp stays meaningful even
    // when the select is wider than MaxSpeedShift needs. The elaboration
    // rate check keeps IncW << MaxSpeedShift below 2^(AccWidth-1), so the
    // shifted step never loses bits.
    always_comb begin
        shift_req = 32'(speed_shift);
        shift_amt = (shift_req > 32'(MaxSpeedShift)) ? 32'(MaxSpeedShift) : shift_req;
        step      = IncW << shift_amt;
        sum       = {1'b0, acc} + {1'b0, step};
    end

    // Carry-out is registered, so a wrap shows up as a tick one cycle
    // later. Pause freezes the phase, which keeps emulated time exact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            tick <= 1'b0;
        end else if (pause) begin
            tick <= 1'b0;
        end else begin
            acc  <= sum[AccWidth-1:0];
            tick <= sum[AccWidth];
        end
    end

endmodule

// File: rtl/retro_catc.sv
// retro_catc
//   Clock-adjusted timing controller. Turns the accumulator tick into the
//   core clock enable, buffers ticks that arrive while the core is stalled
//   and replays them once the stall clears, so no emulated time is lost.
//   Ports:
//     clk, rst_n : fabric clock, asynchronous active-low reset
//     bus        : retro_catc_if.slave
//                  in : stall, pause, speed_shift, clear_ovf
//                  out: clk_en, backlog, overflow, drop_count
module retro_catc
    import retro_catc_pkg::*;
#(
    parameter longint unsigned CoreClock     = 200000000,
    parameter longint unsigned TargetClock   = 8388608,
    parameter int              AccWidth      = 32,
    parameter int              MaxSpeedShift = 1,
    parameter int              BacklogWidth  = 4,
    parameter int              CatchUpGap    = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    retro_catc_if.slave  bus
);

    localparam longint unsigned Inc = catc_increment(CoreClock, TargetClock, AccWidth);
    localparam int GapWidth = (CatchUpGap > 1) ? $clog2(CatchUpGap) : 1;
    localparam logic [GapWidth-1:0]     GapReload  = GapWidth'(CatchUpGap - 1);
    localparam logic [BacklogWidth-1:0] BacklogMax = '1;

    // At most one tick per fabric cycle, even at the fastest speed.
    if (((TargetClock << MaxSpeedShift) * 2) > CoreClock) begin : g_rate_check
        $error("retro_catc: TargetClock << MaxSpeedShift exceeds CoreClock/2");
    end
    if (CatchUpGap < 1) begin : g_gap_check
        $error("retro_catc: CatchUpGap must be at least 1");
    end

    catc_state_t             state_q, state_d;
    logic [BacklogWidth-1:0] backlog_q, backlog_d;
    logic [GapWidth-1:0]     gap_q, gap_d;
    logic                    overflow_q;
    logic [7:0]              drop_q;
    logic                    tick;
    logic                    stall;
    logic                    clk_en;
    logic                    replay;
    logic                    buffer;
    logic                    drop;

    assign stall = bus.stall;

    retro_phase_accum #(
        .AccWidth      (AccWidth),
        .MaxSpeedShift (MaxSpeedShift),
        .Inc           (Inc)
    ) u_accum (
        .clk         (clk),
        .rst_n       (rst_n),
        .pause       (bus.pause),
        .speed_shift (bus.speed_shift),
        .tick        (tick)
    );

    // State, backlog and gap registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            backlog_q <= '0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            backlog_q <= backlog_d;
            gap_q     <= gap_d;
        end
    end

    // Next-state and clk_en decode. clk_en is combinational so it can be
    // gated by the same-cycle stall. A tick arriving on a replay cycle is
    // absorbed by the replay (net backlog change zero) and so can never be
    // dropped. Outside CATCHUP the gap counter keeps draining, so a fresh
    // catch-up still honours the spacing from the last replay; STALL holds it.
    always_comb begin
        state_d   = state_q;
        backlog_d = backlog_q;
        gap_d     = gap_q;
        clk_en    = 1'b0;
        replay    = 1'b0;
        buffer    = 1'b0;
        drop      = 1'b0;

        case (state_q)
            RUN: begin
                if (gap_q != '0) gap_d = gap_q - 1'b1;
                if (stall) begin
                    buffer  = tick;
                    state_d = STALL;
                end else begin
                    clk_en = tick;
                end
            end
            STALL: begin
                buffer = tick;
                if (!stall) state_d = ((backlog_q != '0) || tick) ? CATCHUP : RUN;
            end
            CATCHUP: begin
                buffer = tick;
                if (stall) begin
                    state_d = STALL;
                end else if (gap_q == '0) begin
                    clk_en = 1'b1;
                    replay = 1'b1;
                    gap_d  = GapReload;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = RUN;
        endcase

        if (buffer && !replay) begin
            if (backlog_q == BacklogMax) drop = 1'b1;
            else                         backlog_d = backlog_q + 1'b1;
        end else if (replay && !buffer) begin
            backlog_d = backlog_q - 1'b1;
        end

        if ((state_q == CATCHUP) && !stall && (backlog_d == '0)) state_d = RUN;
    end

    // Sticky overflow and saturating drop count. A drop in the same cycle
    // as a clear wins, leaving exactly that one drop recorded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (bus.clear_ovf)         drop_q <= 8'd1;
            else if (drop_q != 8'hFF)  drop_q <= drop_q + 8'd1;
        end else if (bus.clear_ovf) begin
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end
    end

    assign bus.clk_en     = clk_en;
    assign bus.backlog    = backlog_q;
    assign bus.overflow   = overflow_q;
    assign bus.drop_count = drop_q;

endmodule
